maze_char_ctrl: RTL and testbench
=================================

// Module: maze_char_ctrl
// PURPOSE
//  Character movement controller directly upstream of the maze renderer; sole driver of its char_x/char_y.
//  Debounces four direction buttons and checks the target tile in path_data (1 = open).
//  Updates the character tile position, counts moves, and flags arrival at the goal tile.
// PARAMETERS
//  DEBOUNCE_CYCLES  500_000     cycles a raw button level must be stable before the debounced level changes
//  REPEAT_CYCLES    12_500_000  cycles a held direction waits before an auto-repeat move
//  GRID             64          path_data row pitch in tiles; bit index = x + GRID*y
// PORTS
//  clk          in   1        system clock; all state on posedge
//  reset_n      in   1        asynchronous, active-low reset
//  enable       in   1        1 = accept moves; 0 = hold position, FSM forced to IDLE
//  load         in   1        1-cycle pulse: place character at start, clear counters
//  start_x/y    in   7 each   start tile, sampled on load
//  goal_x/y     in   7 each   goal tile, sampled on load
//  btn_up/down/left/right  in  1 each  raw, asynchronous push buttons, active-high
//  path_data    in   4096     maze tiles, 1 = open path
//  maze_width   in   7        valid columns (1..64)
//  maze_height  in   7        valid rows (1..64)
//  char_x/y     out  7 each   current character tile
//  move_count   out  16       accepted moves since load; saturates at 16'hFFFF
//  moved        out  1        1-cycle pulse on each accepted move
//  blocked      out  1        1-cycle pulse on each rejected move
//  at_goal      out  1        level: char == latched goal
// BEHAVIOUR
//  Reset values: char_x/y = 0, move_count = 0, moved = blocked = at_goal = 0, goal latch = 0, FSM = IDLE.
//  Buttons:
//   - Each button passes a 2-FF synchronizer, then a per-button counter.
//   - Debounced level changes only after DEBOUNCE_CYCLES consecutive equal synced samples.
//   - Direction select when several are debounced high: up > down > left > right.
//  FSM states:
//   - IDLE -> WAIT when enable = 1.
//   - WAIT -> CHECK on rising edge of any debounced button.
//   - CHECK (1 cycle):
//     * Target: up = y-1, down = y+1, left = x-1, right = x+1.
//     * Legal iff no underflow below 0, tx < maze_width, ty < maze_height, and path_data[tx + GRID*ty] = 1.
//     * Legal: char updates at the end of CHECK, moved pulses the same cycle, move_count += 1 (saturating).
//     * Illegal: blocked pulses, position unchanged.
//     * Then -> HOLD.
//   - HOLD:
//     * Repeat timer restarts on entry.
//     * Selected direction still debounced high for REPEAT_CYCLES -> CHECK again, same direction re-evaluated.
//     * All buttons released -> WAIT.
//     * Selected direction changes -> CHECK immediately with the new direction.
//   - DONE: entered when at_goal becomes 1; ignores buttons until load.
//  Latency: debounced rising edge -> char_x/y updated 2 clk later (WAIT->CHECK, CHECK register update).
//  at_goal is registered; asserts the cycle after char equals goal.
//  load: priority over every state and enable.
//   - char <= start, goal latch <= goal, move_count <= 0, FSM <= WAIT (IDLE if enable = 0).
//   - Start == goal gives at_goal next cycle, then DONE.
//  enable falling mid-move: FSM -> IDLE next cycle; position, count and goal are retained.
//  Edge columns/rows never wrap; out-of-range targets are blocked, never indexed.
//  reset_n low at any time: all state to reset values immediately, independent of clk.
// TESTING  (DEBOUNCE_CYCLES = 4, REPEAT_CYCLES = 16)
//  1. Open 4x4 maze, load start (0,0), press right 10 cycles then release.
//     -> char (1,0) exactly 2 clk after debounced edge; moved one pulse; move_count 1.
//  2. At (0,0), press up, then left.
//     -> blocked pulses twice; char stays (0,0); move_count 0.
//  3. path_data bit (1 + 64*0) = 0, press right from (0,0).
//     -> blocked; no move. Bounce btn 1-0-1 every 2 cycles -> no action.
//  4. Hold down 60 cycles on an open column.
//     -> first move, then one repeat move every 16 cycles; y = 0,1,2,3 saturating at the maze_height-1 wall.
//  5. Goal (2,0), move right twice.
//     -> at_goal = 1; third right press ignored (DONE); load start (0,0) -> at_goal 0, move_count 0.
//  6. Assert reset_n low mid-HOLD, asynchronously between clk edges.
//     -> outputs 0 immediately; no moves until load after release.

Source files
------------

// File: rtl/maze_char_ctrl.sv
// Character movement controller for the maze renderer: debounces four direction
// buttons, validates the target tile against path_data and tracks moves and goal arrival.
module maze_char_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_CYCLES   = 12_500_000,
  parameter int GRID            = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          load,
  input  logic [6:0]    start_x,
  input  logic [6:0]    start_y,
  input  logic [6:0]    goal_x,
  input  logic [6:0]    goal_y,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic [4095:0] path_data,
  input  logic [6:0]    maze_width,
  input  logic [6:0]    maze_height,
  output logic [6:0]    char_x,
  output logic [6:0]    char_y,
  output logic [15:0]   move_count,
  output logic          moved,
  output logic          blocked,
  output logic          at_goal
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CHECK, S_HOLD, S_DONE} state_t;

  logic [3:0]      btn_raw;
  logic [3:0]      sync_p0;
  logic [3:0]      sync_p1;
  logic [3:0]      db;
  logic [3:0]      db_q;
  logic [3:0]      rise;
  logic [DB_W-1:0] db_cnt [4];

  state_t          state;
  dir_t            cur_dir;
  dir_t            sel_dir;
  logic            sel_any;
  logic [RP_W-1:0] rpt_cnt;
  logic [6:0]      goal_x_q;
  logic [6:0]      goal_y_q;
  logic            armed;

  logic [7:0]      tx;
  logic [7:0]      ty;
  logic            under;
  int              lin;
  logic            in_range;
  logic [11:0]     idx;
  logic            legal;

  // Bit 0 = up, 1 = down, 2 = left, 3 = right
  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};
  assign rise    = db & ~db_q;

  // Stage p0/p1: two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      db   <= '0;
      db_q <= '0;
    end else begin
      db_q <= db;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_any = |db;
    sel_dir = DIR_UP;
    if (db[0])      sel_dir = DIR_UP;
    else if (db[1]) sel_dir = DIR_DOWN;
    else if (db[2]) sel_dir = DIR_LEFT;
    else if (db[3]) sel_dir = DIR_RIGHT;
  end

  // Target tile; out-of-range targets never reach the path_data select
  always_comb begin
    tx    = {1'b0, char_x};
    ty    = {1'b0, char_y};
    under = 1'b0;
    case (cur_dir)
      DIR_UP:    begin under = (char_y == 7'd0); ty = {1'b0, char_y} - 8'd1; end
      DIR_DOWN:  ty = {1'b0, char_y} + 8'd1;
      DIR_LEFT:  begin under = (char_x == 7'd0); tx = {1'b0, char_x} - 8'd1; end
      default:   tx = {1'b0, char_x} + 8'd1;
    endcase
    lin      = int'(tx) + GRID * int'(ty);
    in_range = !under && (tx < {1'b0, maze_width}) && (ty < {1'b0, maze_height}) && (lin < 4096);
    idx      = in_range ? lin[11:0] : 12'd0;
    legal    = in_range && path_data[idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cur_dir    <= DIR_UP;
      rpt_cnt    <= '0;
      char_x     <= '0;
      char_y     <= '0;
      goal_x_q   <= '0;
      goal_y_q   <= '0;
      move_count <= '0;
      moved      <= 1'b0;
      blocked    <= 1'b0;
      at_goal    <= 1'b0;
      armed      <= 1'b0;
    end else begin
      moved   <= 1'b0;
      blocked <= 1'b0;
      at_goal <= armed && (char_x == goal_x_q) && (char_y == goal_y_q);
      if (load) begin
        char_x     <= start_x;
        char_y     <= start_y;
        goal_x_q   <= goal_x;
        goal_y_q   <= goal_y;
        move_count <= '0;
        at_goal    <= 1'b0;
        armed      <= 1'b1;
        state      <= enable ? S_WAIT : S_IDLE;
      end else if (!enable) begin
        state <= S_IDLE;
      end else if (at_goal) begin
        state <= S_DONE;
      end else begin
        case (state)
          S_IDLE: if (armed) state <= S_WAIT;
          S_WAIT: begin
            if (|rise) begin
              cur_dir <= sel_dir;
              state   <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (legal) begin
              char_x <= tx[6:0];
              char_y <= ty[6:0];
              moved  <= 1'b1;
              if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
            end else begin
              blocked <= 1'b1;
            end
            rpt_cnt <= RP_W'(1);
            state   <= S_HOLD;
          end
          S_HOLD: begin
            if (!sel_any) begin
              state <= S_WAIT;
            end else if (sel_dir != cur_dir) begin
              cur_dir <= sel_dir;
              state   <= S_CHECK;
            end else if (rpt_cnt >= RP_LAST) begin
              state <= S_CHECK;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
          S_DONE:  state <= S_DONE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_maze_char_ctrl.sv
// Bench for maze_char_ctrl: directed scenarios plus random walks scored by a tile-level model.
module tb_maze_char_ctrl;

  localparam int DB   = 4;
  localparam int RP   = 16;
  localparam int SYNC = 2;
  // raw press -> synchronizer -> DB samples -> WAIT->CHECK -> register update
  localparam int LAT  = SYNC + DB + 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [6:0]    start_x = '0, start_y = '0, goal_x = '0, goal_y = '0;
  logic [3:0]    btn = '0;
  logic [4095:0] path_data = '1;
  logic [6:0]    maze_width = 7'd4, maze_height = 7'd4;
  logic [6:0]    char_x, char_y;
  logic [15:0]   move_count;
  logic          moved, blocked, at_goal;

  int checks = 0, errors = 0;
  int n_moved = 0, n_blocked = 0;
  int mx, my, mgx, mgy, mcnt;
  bit mdone;

  maze_char_ctrl #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP), .GRID(64)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
    .start_x(start_x), .start_y(start_y), .goal_x(goal_x), .goal_y(goal_y),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
    .path_data(path_data), .maze_width(maze_width), .maze_height(maze_height),
    .char_x(char_x), .char_y(char_y), .move_count(move_count),
    .moved(moved), .blocked(blocked), .at_goal(at_goal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (moved)   n_moved++;
    if (blocked) n_blocked++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(input int sx, input int sy, input int gx, input int gy);
    start_x = 7'(sx); start_y = 7'(sy); goal_x = 7'(gx); goal_y = 7'(gy);
    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(2);
    mx = sx; my = sy; mgx = gx; mgy = gy; mcnt = 0;
    mdone = (sx == gx) && (sy == gy);
  endtask

  // Short press: one move, released before any auto-repeat, then settle
  task automatic press(input int dir);
    btn = '0;
    btn[dir] = 1'b1;
    tick(10);
    btn = '0;
    tick(20);
  endtask

  // Reference: a press moves one tile if the target is inside the maze and open
  task automatic model_press(input int dir, output bit mv, output bit bl);
    int tx, ty;
    tx = mx; ty = my; mv = 0; bl = 0;
    case (dir)
      0: ty = my - 1;
      1: ty = my + 1;
      2: tx = mx - 1;
      default: tx = mx + 1;
    endcase
    if (!mdone) begin
      if (tx >= 0 && ty >= 0 && tx < int'(maze_width) && ty < int'(maze_height)
          && path_data[tx + 64 * ty]) begin
        mx = tx; my = ty; mcnt++; mv = 1;
      end else begin
        bl = 1;
      end
      if (mx == mgx && my == mgy) mdone = 1;
    end
  endtask

  initial begin
    int pm, pb;
    bit mv, bl;

    // Reset state
    tick(3);
    chk("rst_char_x", char_x, 0);
    chk("rst_char_y", char_y, 0);
    chk("rst_count", move_count, 0);
    chk("rst_moved", moved, 0);
    chk("rst_blocked", blocked, 0);
    chk("rst_at_goal", at_goal, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    tick(2);

    // 1: single right press, exact latency
    do_load(0, 0, 63, 63);
    pm = n_moved; pb = n_blocked;
    btn[3] = 1'b1;
    tick(LAT - 1);
    chk("t1_before_x", char_x, 0);
    tick(1);
    chk("t1_at_lat_x", char_x, 1);
    chk("t1_moved_pulse", moved, 1);
    tick(10 - LAT);
    btn = '0;
    tick(20);
    chk("t1_y", char_y, 0);
    chk("t1_count", move_count, 1);
    chk("t1_moved_n", n_moved - pm, 1);
    chk("t1_blocked_n", n_blocked - pb, 0);

    // 2: edge walls
    do_load(0, 0, 63, 63);
    pm = n_moved; pb = n_blocked;
    press(0);
    press(2);
    chk("t2_blocked_n", n_blocked - pb, 2);
    chk("t2_moved_n", n_moved - pm, 0);
    chk("t2_x", char_x, 0);
    chk("t2_y", char_y, 0);
    chk("t2_count", move_count, 0);

    // 3: closed tile, then bouncing button
    path_data[1] = 1'b0;
    do_load(0, 0, 63, 63);
    pm = n_moved; pb = n_blocked;
    press(3);
    chk("t3_blocked_n", n_blocked - pb, 1);
    chk("t3_x", char_x, 0);
    pb = n_blocked;
    for (int i = 0; i < 12; i++) begin
      btn[3] = ((i % 4) < 2);
      tick(1);
    end
    btn = '0;
    tick(20);
    chk("t3_bounce_blocked", n_blocked - pb, 0);
    chk("t3_bounce_moved", n_moved - pm, 0);
    path_data[1] = 1'b1;

    // 4: held down with auto-repeat up to the bottom wall
    do_load(0, 0, 63, 63);
    pm = n_moved; pb = n_blocked;
    btn[1] = 1'b1;
    tick(LAT);
    chk("t4_y1", char_y, 1);
    tick(RP - 1);
    chk("t4_y1_hold", char_y, 1);
    tick(1);
    chk("t4_y2", char_y, 2);
    tick(RP);
    chk("t4_y3", char_y, 3);
    tick(RP);
    chk("t4_wall_blocked", blocked, 1);
    tick(60 - LAT - 3 * RP);
    btn = '0;
    tick(20);
    chk("t4_y_final", char_y, 3);
    chk("t4_count", move_count, 3);
    chk("t4_moved_n", n_moved - pm, 3);
    chk("t4_blocked_n", n_blocked - pb, 1);

    // 5: reach goal, DONE ignores buttons, reload clears
    do_load(0, 0, 2, 0);
    press(3);
    chk("t5_not_goal", at_goal, 0);
    press(3);
    chk("t5_at_goal", at_goal, 1);
    chk("t5_count", move_count, 2);
    pm = n_moved; pb = n_blocked;
    press(3);
    chk("t5_done_x", char_x, 2);
    chk("t5_done_moved", n_moved - pm, 0);
    chk("t5_done_blocked", n_blocked - pb, 0);
    do_load(0, 0, 2, 0);
    chk("t5_reload_goal", at_goal, 0);
    chk("t5_reload_count", move_count, 0);
    chk("t5_reload_x", char_x, 0);

    // 6: asynchronous reset in the middle of HOLD
    do_load(0, 0, 63, 63);
    btn[1] = 1'b1;
    tick(LAT + 4);
    chk("t6_pre_y", char_y, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_async_y", char_y, 0);
    chk("t6_async_count", move_count, 0);
    chk("t6_async_moved", moved, 0);
    btn = '0;
    tick(3);
    reset_n = 1'b1;
    pm = n_moved; pb = n_blocked;
    press(3);
    press(1);
    chk("t6_nomove_x", char_x, 0);
    chk("t6_nomove_y", char_y, 0);
    chk("t6_nomove_n", n_moved - pm, 0);
    chk("t6_noblock_n", n_blocked - pb, 0);
    do_load(1, 1, 63, 63);
    press(3);
    chk("t6_after_load_x", char_x, 2);
    chk("t6_after_load_cnt", move_count, 1);

    // Random mazes and walks
    for (int r = 0; r < 3; r++) begin
      maze_width  = 7'($urandom_range(8, 2));
      maze_height = 7'($urandom_range(8, 2));
      path_data   = '1;
      for (int y = 0; y < int'(maze_height); y++)
        for (int x = 0; x < int'(maze_width); x++)
          path_data[x + 64 * y] = ($urandom_range(3, 0) != 0);
      do_load($urandom_range(int'(maze_width) - 1, 0), $urandom_range(int'(maze_height) - 1, 0),
              $urandom_range(int'(maze_width) - 1, 0), $urandom_range(int'(maze_height) - 1, 0));
      for (int p = 0; p < 15; p++) begin
        int d;
        d  = $urandom_range(3, 0);
        pm = n_moved; pb = n_blocked;
        press(d);
        model_press(d, mv, bl);
        chk("rnd_x", char_x, mx);
        chk("rnd_y", char_y, my);
        chk("rnd_count", move_count, mcnt);
        chk("rnd_at_goal", at_goal, mdone);
        chk("rnd_moved_n", n_moved - pm, mv);
        chk("rnd_blocked_n", n_blocked - pb, bl);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
